// File: rtl/spm_arbiter.sv
// spm_arbiter: shares the single-port scratchpad between the test port (tst),
// the CPU data port (dat) and the CPU fetch port (ins). Fixed priority
// tst > dat > ins, with fetch boosted above dat after a run of denials.
// One grant per cycle; the acknowledge is registered and lands one cycle later.
module spm_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_CNT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] tst_addr,
  input  logic              tst_as_,
  input  logic              tst_rw,
  input  logic [DATA_W-1:0] tst_wr_data,
  output logic              tst_rdy,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic              dat_as_,
  input  logic              dat_rw,
  input  logic [DATA_W-1:0] dat_wr_data,
  output logic              dat_rdy,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic              ins_as_,
  output logic              ins_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  logic tst_v, dat_v, ins_v;
  logic tst_elig, dat_elig, ins_elig;
  logic boost;
  logic gnt_tst, gnt_dat, gnt_ins;

  logic                    tst_rdy_q, tst_rdy_d;
  logic                    dat_rdy_q, dat_rdy_d;
  logic                    ins_rdy_q, ins_rdy_d;
  logic                    rd_ack_q, rd_ack_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  // Eligibility (a requester being acknowledged cannot be re-granted) and priority grant
  always_comb begin
    tst_v    = ~tst_as_;
    dat_v    = ~dat_as_;
    ins_v    = ~ins_as_;
    tst_elig = tst_v & ~tst_rdy_q;
    dat_elig = dat_v & cpu_en & ~dat_rdy_q;
    ins_elig = ins_v & cpu_en & ~ins_rdy_q;
    boost    = (starve_q == STARVE_MAX);
    gnt_tst  = 1'b0;
    gnt_dat  = 1'b0;
    gnt_ins  = 1'b0;
    if (!reset) begin
      if (tst_elig)               gnt_tst = 1'b1;
      else if (ins_elig && boost) gnt_ins = 1'b1;
      else if (dat_elig)          gnt_dat = 1'b1;
      else if (ins_elig)          gnt_ins = 1'b1;
    end
  end

  // Steer the granted request onto the SPM; idle values otherwise
  always_comb begin
    spm_as_     = 1'b1;
    spm_rw      = 1'b1;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (gnt_tst) begin
      spm_as_     = 1'b0;
      spm_rw      = tst_rw;
      spm_addr    = tst_addr;
      spm_wr_data = tst_wr_data;
    end else if (gnt_dat) begin
      spm_as_     = 1'b0;
      spm_rw      = dat_rw;
      spm_addr    = dat_addr;
      spm_wr_data = dat_wr_data;
    end else if (gnt_ins) begin
      spm_as_     = 1'b0;
      spm_addr    = ins_addr;
    end
  end

  // Next acknowledge state and fetch starvation counter (holds while cpu_en is low)
  always_comb begin
    tst_rdy_d = gnt_tst;
    dat_rdy_d = gnt_dat;
    ins_rdy_d = gnt_ins;
    rd_ack_d  = (gnt_tst & tst_rw) | (gnt_dat & dat_rw) | gnt_ins;
    starve_d  = starve_q;
    if (gnt_ins || !ins_v)
      starve_d = '0;
    else if (ins_elig && (starve_q != STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  // Registered state with synchronous reset; a pending ack is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      tst_rdy_q <= 1'b0;
      dat_rdy_q <= 1'b0;
      ins_rdy_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      starve_q  <= '0;
    end else begin
      tst_rdy_q <= tst_rdy_d;
      dat_rdy_q <= dat_rdy_d;
      ins_rdy_q <= ins_rdy_d;
      rd_ack_q  <= rd_ack_d;
      starve_q  <= starve_d;
    end
  end

  // Reset masks the ack outputs in the same cycle it is asserted
  assign tst_rdy = tst_rdy_q & ~reset;
  assign dat_rdy = dat_rdy_q & ~reset;
  assign ins_rdy = ins_rdy_q & ~reset;
  assign rd_data = (rd_ack_q && !reset) ? spm_rd_data : '0;

endmodule

// File: doc/spm_arbiter.md
Name: spm_arbiter

Overview:
- Shares the single-port scratchpad memory (SPM) between three requesters:
  - the bench/loader test port (tst);
  - the CPU memory-stage data port (dat);
  - the CPU instruction-fetch port (ins).
- Sits between cpu_top's fetch/mem stages, the test_spm_* interface and the SPM.
- Fixed priority tst > dat > ins, with an anti-starvation boost for ins.
- One access granted per cycle; acknowledge returns one cycle after grant.

Parameters:
ADDR_W, 30, word address width (SPM word-addressed)
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied eligible cycles before ins is boosted above dat
STARVE_CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_en  in  1  1 = CPU ports (dat, ins) may be granted; 0 = only tst served
tst_addr  in  ADDR_W  test request address
tst_as_  in  1  test request strobe, active-low
tst_rw  in  1  1 = read, 0 = write
tst_wr_data  in  DATA_W  test write data
tst_rdy  out  1  test access acknowledged
dat_addr / dat_as_ / dat_rw / dat_wr_data  in  ADDR_W/1/1/DATA_W  data-port request, same encoding as tst
dat_rdy  out  1  data access acknowledged
ins_addr / ins_as_  in  ADDR_W/1  fetch request; always a read
ins_rdy  out  1  fetch acknowledged
rd_data  out  DATA_W  read data, valid with any rdy of a read
spm_addr  out  ADDR_W  SPM address
spm_as_  out  1  SPM strobe, active-low
spm_rw  out  1  1 = read, 0 = write
spm_wr_data  out  DATA_W  SPM write data
spm_rd_data  in  DATA_W  SPM read data, one cycle after strobed read

Behaviour:
Request rules:
- A requester is valid when its as_ = 0.
- It holds addr/rw/wr_data stable until it sees its rdy.
- It may drop or issue a new request in the cycle after rdy.

Eligibility:
- A requester is eligible when valid and not being acknowledged this cycle (its rdy = 0).
- dat and ins are additionally gated by cpu_en = 1.

Arbitration (combinational, each cycle):
- tst eligible -> tst.
- Else ins eligible and boost = 1 -> ins.
- Else dat eligible -> dat.
- Else ins eligible -> ins.
- Else none.

SPM drive (combinational from grant):
- Granted requester's addr/rw/wr_data drive the SPM, with spm_as_ = 0.
- ins drives spm_rw = 1.
- No grant: spm_as_ = 1, spm_rw = 1, spm_addr = 0, spm_wr_data = 0.

Acknowledge (registered):
- Grant in cycle N -> that requester's rdy = 1 in cycle N+1, for exactly one cycle.
- For reads, rd_data = spm_rd_data in cycle N+1.
- For writes, and in cycles with no rdy, rd_data = 0.
- At most one rdy high per cycle.
- Throughput is one access per cycle; back-to-back grants to different requesters are allowed.

Starvation counter:
- Increments, saturating at STARVE_LIMIT, each cycle ins is eligible but not granted.
- Clears on an ins grant, and when ins is not valid.
- boost = (counter == STARVE_LIMIT). boost never overrides tst.

cpu_en falling:
- An already-granted access still acknowledges next cycle.
- No new dat/ins grants are made.
- The starvation counter holds its value.

Reset (any cycle, including a pending ack):
- Registered state cleared next edge: all rdy = 0, rd_data = 0, counter = 0.
- A pending acknowledge is discarded.
- SPM outputs show idle values whenever reset = 1.

Test Plan:
1. Write/read through tst:
   - Cycle 0: tst write addr 5, data 32'hDEADBEEF -> cycle 1 tst_rdy = 1.
   - Cycle 2: tst read addr 5 -> cycle 3 tst_rdy = 1, rd_data = 32'hDEADBEEF.
2. cpu_en gating:
   - cpu_en = 0, ins_as_ = 0 held 10 cycles -> ins_rdy never 1, spm_as_ stays 1.
   - Raise cpu_en -> spm_as_ = 0 with ins_addr that cycle, ins_rdy next cycle.
3. Simultaneous requests (cycle 0): tst read 0, dat write 16 = 3, ins read 8; each requester drops its strobe after its rdy.
   - Grants occur at cycles 0/1/2 in order tst, dat, ins.
   - rdys appear at cycles 1/2/3.
   - Each rdy is one-hot.
4. Starvation boost (STARVE_LIMIT = 4):
   - Stimulus: tst and dat re-request every cycle after their ack; ins held.
   - Grants run tst, dat, tst, dat, tst, then ins at cycle 5 (boost beats dat).
   - Counter returns to 0 after the ins grant.
5. Reset mid-read:
   - dat read granted at cycle N, reset = 1 at cycle N+1.
   - Cycle N+1 rdy is suppressed; outputs idle (spm_as_ = 1, rd_data = 0).
   - No ack appears after reset deasserts.
6. Cross-requester coherence:
   - dat write addr 16 = 32'h00000003, then tst read addr 16.
   - tst_rdy asserts with rd_data = 32'h00000003.
